// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// Each conversion consumes one input bit per clock through one row of
// add-3 correction, finishing in WIDTH cycles with a one-cycle done pulse.
module bcd_convert_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = 4*DIGITS + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sreg_q, sreg_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;

    logic [4*DIGITS-1:0]   corr;
    logic [TW-1:0]         shifted;

    // One row of add-3 correction followed by the 1-bit shift of the whole
    // {digits, operand} register; the operand MSB enters digit 0 bit 0.
    always_comb begin
        corr = digits_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {corr, sreg_q} << 1;
    end

    // Next-state and datapath control: accept in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sreg_d   = bin;
                    digits_d = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SHIFT: begin
                digits_d = shifted[TW-1 -: 4*DIGITS];
                sreg_d   = shifted[WIDTH-1:0];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[TW-1 -: 4*DIGITS];
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: default (10-bit, 4-digit) and
// reduced (8-bit, 3-digit) instances against a decimal-digit reference model.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [11:0] bcd8;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int expected_done = 0;
    int viol = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.WIDTH(10), .DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bcd_convert_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8)
    );

    // Decimal digits by plain division, packed one digit per nibble.
    function automatic logic [31:0] to_bcd(input int unsigned n, input int unsigned nd);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int unsigned i = 0; i < nd; i++) begin
            r = r | (32'(v % 10) << (4*i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor on the main instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_seen++;
            if (done && busy) viol++;
            if (done && done_prev) viol++;
        end
        done_prev = done;
    end

    task automatic run_conv(input logic [9:0] v);
        int lat;
        int busy_cnt;
        start = 1'b1;
        bin   = v;
        tick();
        lat   = 1;
        start = 1'b0;
        bin   = 10'($urandom);
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check("timeout", 32'(done), 32'd1);
        if (done) begin
            expected_done++;
            check("bcd", 32'(bcd), to_bcd(32'(v), 4));
            check("latency", 32'(lat), 32'd11);
            check("busy_cycles", 32'(busy_cnt), 32'd10);
        end
    endtask

    task automatic run_conv8(input logic [7:0] v);
        int lat;
        int busy_cnt;
        start8 = 1'b1;
        bin8   = v;
        tick();
        lat    = 1;
        start8 = 1'b0;
        bin8   = 8'($urandom);
        busy_cnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        check("timeout8", 32'(done8), 32'd1);
        if (done8) begin
            check("bcd8", 32'(bcd8), to_bcd(32'(v), 3));
            check("busy_cycles8", 32'(busy_cnt), 32'd8);
        end
    endtask

    initial begin
        int n;
        int stab_viol;
        rst    = 1'b1;
        start  = 1'b0;
        bin    = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (2) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd",  32'(bcd),  32'd0);
        rst = 1'b0;
        tick();

        // Directed values.
        run_conv(10'd0);
        tick();
        run_conv(10'd1023);
        run_conv(10'd255);
        tick();
        run_conv(10'd5);
        run_conv(10'd999);
        tick();

        // Exhaustive sweep with random idle gaps (0 gap = back-to-back).
        for (int v = 0; v < 1024; v++) begin
            run_conv(10'(v));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Random values.
        for (int k = 0; k < 100; k++) begin
            run_conv(10'($urandom));
            repeat ($urandom_range(0, 1)) tick();
        end
        tick();

        // start during busy is ignored.
        start = 1'b1;
        bin   = 10'd100;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        bin   = 10'd7;
        tick();
        start = 1'b0;
        bin   = '0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("ign_timeout", 32'(done), 32'd1);
        if (done) expected_done++;
        check("ign_bcd", 32'(bcd), 32'h0100);
        tick();
        check("ign_no_extra_done", 32'(done), 32'd0);
        check("ign_not_queued", 32'(busy), 32'd0);
        tick();

        // Held start: back-to-back conversions, operand changed during busy.
        start = 1'b1;
        bin   = 10'd42;
        tick();
        bin = 10'd43;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("b2b1_timeout", 32'(done), 32'd1);
        if (done) expected_done++;
        check("b2b1_bcd", 32'(bcd), 32'h0042);
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        n = 0;
        stab_viol = 0;
        while (!done && n < 40) begin
            if (bcd !== 16'h0042) stab_viol++;
            tick();
            n++;
        end
        check("b2b2_timeout", 32'(done), 32'd1);
        if (done) expected_done++;
        check("b2b_bcd_stable", 32'(stab_viol), 32'd0);
        check("b2b_interval", 32'(n + 1), 32'd11);
        check("b2b2_bcd", 32'(bcd), 32'h0043);
        tick();

        // Reset aborts a conversion in flight.
        run_conv(10'd512);
        tick();
        start = 1'b1;
        bin   = 10'd777;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd",  32'(bcd),  32'd0);
        rst = 1'b0;
        repeat (12) tick();
        check("abort_no_done", 32'(done), 32'd0);
        run_conv(10'd777);
        tick();

        // Reduced-width instance.
        run_conv8(8'd255);
        tick();
        run_conv8(8'd0);
        for (int k = 0; k < 20; k++) begin
            run_conv8(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("done_count", 32'(done_seen), 32'(expected_done));
        check("protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
